// File: rtl/demo_pkg.sv
// Shared types and voice-word layout for the demo song sequencer.
package demo_pkg;

  localparam int VOICE_W   = 16;
  localparam int PITCH_LSB = 4;
  localparam int VOL_LSB   = 2;
  localparam int WAVE_LSB  = 0;
  localparam int PITCH_W   = 12;
  localparam int VOL_W     = 2;
  localparam int WAVE_W    = 2;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DONE} state_t;

  typedef struct packed {
    logic [PITCH_W-1:0] pitch;
    logic [VOL_W-1:0]   vol;
    logic [WAVE_W-1:0]  wave;
  } voice_t;

  function automatic voice_t unpack_voice(input logic [VOICE_W-1:0] word);
    voice_t v;
    v.pitch = word[PITCH_LSB +: PITCH_W];
    v.vol   = word[VOL_LSB +: VOL_W];
    v.wave  = word[WAVE_LSB +: WAVE_W];
    return v;
  endfunction

endpackage

// File: rtl/demo_voice_expand.sv
// Combinational fan-out of one voice word onto its group of SPREAD synth channels.
module demo_voice_expand
  import demo_pkg::*;
#(
  parameter int C      = 12,
  parameter int SPREAD = 4
) (
  input  voice_t                voice,
  output logic [SPREAD*C-1:0]   pitch,
  output logic [SPREAD*2-1:0]   wave,
  output logic [SPREAD-1:0]     ena
);

  for (genvar gi = 0; gi < SPREAD; gi++) begin : g_chan
    assign pitch[gi*C +: C] = C'(voice.pitch);
    assign wave[gi*2 +: 2]  = voice.wave;
    // Volume code selects how many channels, from the lowest upwards, sound
    assign ena[gi] = (voice.vol == 2'd3) ||
                     ((voice.vol == 2'd2) && (gi < SPREAD/2)) ||
                     ((voice.vol == 2'd1) && (gi == 0));
  end

endmodule

// File: rtl/demo_sequencer.sv
// Demo song player: steps a song ROM at a programmable tempo and drives the synth channel bank.
module demo_sequencer
  import demo_pkg::*;
#(
  parameter int SONG_LENGTH = 128,
  parameter int NUM         = 25,
  parameter int C           = 12,
  parameter int VOICES      = 6,
  parameter int SPREAD      = 4,
  parameter int ROM_LATENCY = 1,
  parameter int TEMPO_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           play,
  input  logic                           stop,
  input  logic                           loop_mode,
  input  logic [TEMPO_W-1:0]             tempo_div,
  output logic [$clog2(SONG_LENGTH)-1:0] rom_addr,
  output logic                           rom_en,
  input  logic [VOICES*VOICE_W-1:0]      rom_data,
  output logic [NUM*C-1:0]               demo_pitches,
  output logic [NUM*2-1:0]               demo_waveforms,
  output logic [NUM-1:0]                 demo_channel_ena,
  output logic                           playing,
  output logic                           song_done
);

  localparam int AW     = $clog2(SONG_LENGTH);
  localparam int WW     = $clog2(ROM_LATENCY + 1);
  localparam int MINLEN = ROM_LATENCY + 2;
  localparam int CW     = ((TEMPO_W > $clog2(MINLEN + 1)) ? TEMPO_W : $clog2(MINLEN + 1)) + 1;
  localparam int USED   = VOICES * SPREAD;
  localparam logic [AW-1:0] LAST = AW'(SONG_LENGTH - 1);

  state_t            state;
  logic [WW-1:0]     wait_cnt;
  logic [CW-1:0]     hold_cnt;
  logic [CW-1:0]     step_len;
  logic [CW-1:0]     hold_len;
  logic [NUM*C-1:0]  pitch_exp;
  logic [NUM*2-1:0]  wave_exp;
  logic [NUM-1:0]    ena_exp;

  // HOLD covers whatever is left of the step after the FETCH and WAIT cycles
  always_comb begin
    step_len = (CW'(tempo_div) > CW'(MINLEN)) ? CW'(tempo_div) : CW'(MINLEN);
    hold_len = step_len - CW'(ROM_LATENCY + 1);
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
    voice_t voice;
    assign voice = unpack_voice(rom_data[gi*VOICE_W +: VOICE_W]);
    demo_voice_expand #(.C(C), .SPREAD(SPREAD)) u_expand (
      .voice (voice),
      .pitch (pitch_exp[(VOICES-1-gi)*SPREAD*C +: SPREAD*C]),
      .wave  (wave_exp[(VOICES-1-gi)*SPREAD*2 +: SPREAD*2]),
      .ena   (ena_exp[(VOICES-1-gi)*SPREAD +: SPREAD])
    );
  end

  if (USED < NUM) begin : g_unused
    assign pitch_exp[NUM*C-1:USED*C] = '0;
    assign wave_exp[NUM*2-1:USED*2]  = '0;
    assign ena_exp[NUM-1:USED]       = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rom_addr         <= '0;
      rom_en           <= 1'b0;
      wait_cnt         <= '0;
      hold_cnt         <= '0;
      demo_pitches     <= '0;
      demo_waveforms   <= '0;
      demo_channel_ena <= '0;
      playing          <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        state            <= IDLE;
        rom_addr         <= '0;
        rom_en           <= 1'b0;
        demo_pitches     <= '0;
        demo_waveforms   <= '0;
        demo_channel_ena <= '0;
        playing          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              state   <= FETCH;
              rom_en  <= 1'b1;
              playing <= 1'b1;
            end
          end
          FETCH: begin
            rom_en   <= 1'b0;
            wait_cnt <= WW'(ROM_LATENCY - 1);
            hold_cnt <= hold_len;
            state    <= WAIT;
          end
          WAIT: begin
            if (wait_cnt == '0) begin
              demo_pitches     <= pitch_exp;
              demo_waveforms   <= wave_exp;
              demo_channel_ena <= ena_exp;
              state            <= HOLD;
            end else begin
              wait_cnt <= wait_cnt - WW'(1);
            end
          end
          HOLD: begin
            if (play) begin
              if (hold_cnt <= CW'(1)) begin
                if (rom_addr != LAST) begin
                  rom_addr <= rom_addr + AW'(1);
                  rom_en   <= 1'b1;
                  state    <= FETCH;
                end else if (loop_mode) begin
                  rom_addr <= '0;
                  rom_en   <= 1'b1;
                  state    <= FETCH;
                end else begin
                  rom_addr         <= '0;
                  demo_pitches     <= '0;
                  demo_waveforms   <= '0;
                  demo_channel_ena <= '0;
                  playing          <= 1'b0;
                  song_done        <= 1'b1;
                  state            <= DONE;
                end
              end else begin
                hold_cnt <= hold_cnt - CW'(1);
              end
            end
          end
          DONE: begin
            if (!play) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer: two instances (ROM latency 1 and 3) on a 4-step song.
module tb_demo_sequencer;

  localparam int NUM = 25;
  localparam int C   = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              play;
  logic              stop;
  logic              loop_mode;
  logic [15:0]       tempo_div;

  logic [1:0]        rom_addr, rom_addr3;
  logic              rom_en, rom_en3;
  logic [95:0]       rom_data, rom_data3;
  logic [NUM*C-1:0]  pitches, pitches3;
  logic [NUM*2-1:0]  waves, waves3;
  logic [NUM-1:0]    ena, ena3;
  logic              playing, playing3;
  logic              song_done, song_done3;

  logic [95:0] mem [4];
  logic [95:0] s1, s2, s3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sd_pulses = 0;

  always #5 clk = ~clk;

  demo_sequencer #(.SONG_LENGTH(4), .ROM_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop_mode(loop_mode),
    .tempo_div(tempo_div), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .demo_pitches(pitches), .demo_waveforms(waves), .demo_channel_ena(ena),
    .playing(playing), .song_done(song_done)
  );

  demo_sequencer #(.SONG_LENGTH(4), .ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop_mode(loop_mode),
    .tempo_div(tempo_div), .rom_addr(rom_addr3), .rom_en(rom_en3), .rom_data(rom_data3),
    .demo_pitches(pitches3), .demo_waveforms(waves3), .demo_channel_ena(ena3),
    .playing(playing3), .song_done(song_done3)
  );

  initial begin
    mem[0] = {16'h1230, 64'h0, 16'hABCF};
    mem[1] = {16'h4565, 80'h0};
    mem[2] = {16'h789A, 80'h0};
    mem[3] = {16'hDEFF, 80'h0};
  end

  // ROM models: latency 1 for u_dut, latency 3 for u_dut3
  always @(posedge clk) begin
    if (rom_en) rom_data <= mem[rom_addr];
    if (rom_en3) s1 <= mem[rom_addr3];
    s2 <= s1;
    s3 <= s2;
  end
  assign rom_data3 = s3;

  always @(negedge clk) if (song_done) sd_pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_en(input int which);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (((which == 0) ? rom_en : rom_en3) !== 1'b1 && n < 100);
    if (n >= 100) chk("rom_en_timeout", 64'(n), 64'(0));
  endtask

  int t_prev;
  int snap_sd;
  logic [NUM-1:0] snap_ena;
  logic [11:0] snap_pitch;
  logic [3:0] exp_low [4];

  initial begin
    exp_low[0] = 4'h0; exp_low[1] = 4'h1; exp_low[2] = 4'h3; exp_low[3] = 4'hF;
    rst_n = 1'b0; play = 1'b0; stop = 1'b0; loop_mode = 1'b0; tempo_div = 16'd10;
    repeat (3) tick();
    chk("reset_rom_en", 64'(rom_en), 64'(0));
    chk("reset_rom_addr", 64'(rom_addr), 64'(0));
    chk("reset_ena", 64'(ena), 64'(0));
    chk("reset_playing", 64'(playing), 64'(0));
    chk("reset_song_done", 64'(song_done), 64'(0));
    rst_n = 1'b1;
    play = 1'b1;

    // One-shot play of all four steps with data, timing and enable checks
    for (int s = 0; s < 4; s++) begin
      wait_en(0);
      $display("step %0d rom_en at cycle %0d addr %0d", s, cyc, rom_addr);
      chk($sformatf("addr_step%0d", s), 64'(rom_addr), 64'(s));
      if (s > 0) chk($sformatf("interval_step%0d", s), 64'(cyc - t_prev), 64'(10));
      t_prev = cyc;
      tick();
      if (s == 0) chk("no_early_update", 64'(ena), 64'(0));
      tick();
      chk($sformatf("ena_low_step%0d", s), 64'(ena[3:0]), 64'(exp_low[s]));
      if (s == 0) begin
        chk("ch20_pitch", 64'(pitches[20*C +: C]), 64'h0ABC);
        chk("ch23_pitch", 64'(pitches[23*C +: C]), 64'h0ABC);
        chk("ch20_wave", 64'(waves[20*2 +: 2]), 64'h3);
        chk("ena_step0", 64'(ena), 64'h0F00000);
        chk("ch24_pitch", 64'(pitches[24*C +: C]), 64'h0);
        chk("ch24_wave", 64'(waves[24*2 +: 2]), 64'h0);
        chk("playing_step0", 64'(playing), 64'(1));
      end
      if (s == 1) chk("ch0_pitch_step1", 64'(pitches[11:0]), 64'h456);
    end

    begin
      int n;
      n = 0;
      while (song_done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
    end
    $display("song_done at cycle %0d", cyc);
    chk("song_done_time", 64'(cyc - t_prev), 64'(10));
    chk("done_ena", 64'(ena), 64'(0));
    chk("done_pitches", 64'(pitches[63:0]), 64'(0));
    chk("done_addr", 64'(rom_addr), 64'(0));
    chk("done_playing", 64'(playing), 64'(0));
    tick();
    chk("song_done_one_cycle", 64'(song_done), 64'(0));
    repeat (5) tick();
    chk("done_waits_play_low", 64'(playing), 64'(0));
    chk("done_no_rom_en", 64'(rom_en), 64'(0));
    chk("song_done_pulses", 64'(sd_pulses), 64'(1));

    // Loop mode: 0,1,2,3,0,1 with no completion pulse
    play = 1'b0;
    tick();
    loop_mode = 1'b1;
    play = 1'b1;
    snap_sd = sd_pulses;
    for (int k = 0; k < 6; k++) begin
      wait_en(0);
      $display("loop rom_en at cycle %0d addr %0d", cyc, rom_addr);
      chk($sformatf("loop_addr%0d", k), 64'(rom_addr), 64'(k % 4));
      if (k > 0) chk($sformatf("loop_interval%0d", k), 64'(cyc - t_prev), 64'(10));
      t_prev = cyc;
    end
    chk("loop_no_song_done", 64'(sd_pulses), 64'(snap_sd));

    // Pause for 7 cycles in HOLD of step 1
    repeat (4) tick();
    snap_ena = ena;
    snap_pitch = pitches[11:0];
    chk("pre_pause_ena", 64'(snap_ena), 64'h1);
    play = 1'b0;
    repeat (7) tick();
    chk("pause_ena_held", 64'(ena), 64'(snap_ena));
    chk("pause_pitch_held", 64'(pitches[11:0]), 64'(snap_pitch));
    chk("pause_playing", 64'(playing), 64'(1));
    play = 1'b1;
    wait_en(0);
    $display("post-pause rom_en at cycle %0d addr %0d", cyc, rom_addr);
    chk("pause_interval", 64'(cyc - t_prev), 64'(17));
    chk("pause_addr", 64'(rom_addr), 64'(2));

    // Stop while in WAIT
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    $display("stop applied at cycle %0d", cyc);
    chk("stop_playing", 64'(playing), 64'(0));
    chk("stop_addr", 64'(rom_addr), 64'(0));
    chk("stop_ena", 64'(ena), 64'(0));
    chk("stop_rom_en", 64'(rom_en), 64'(0));
    tick();
    chk("restart_rom_en", 64'(rom_en), 64'(1));
    chk("restart_addr", 64'(rom_addr), 64'(0));

    // Minimum step length with ROM latency 3, then async reset mid-HOLD
    play = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tempo_div = 16'd0;
    tick();
    play = 1'b1;
    wait_en(1);
    chk("lat3_addr0", 64'(rom_addr3), 64'(0));
    t_prev = cyc;
    wait_en(1);
    $display("lat3 rom_en at cycle %0d addr %0d", cyc, rom_addr3);
    chk("lat3_interval", 64'(cyc - t_prev), 64'(5));
    chk("lat3_addr1", 64'(rom_addr3), 64'(1));
    repeat (3) tick();
    chk("lat3_no_early_update", 64'(ena3), 64'h0F00000);
    tick();
    chk("lat3_ena_step1", 64'(ena3), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset at time %0t", $time);
    chk("async_ena3", 64'(ena3), 64'(0));
    chk("async_playing3", 64'(playing3), 64'(0));
    chk("async_addr3", 64'(rom_addr3), 64'(0));
    chk("async_rom_en", 64'(rom_en), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demo_sequencer.md
Name: demo_sequencer

Overview:
- Parametrised next-generation demo player.
- Steps through a song ROM at a runtime-programmable tempo and decodes VOICES packed 16-bit voice words into per-channel pitch, waveform and enable buses for the synth channel bank.
- Adds over the previous demo path:
  - registered outputs;
  - ROM read-latency handling;
  - play/pause/stop control;
  - loop versus one-shot mode;
  - end-of-song signalling.

Parameters:
- SONG_LENGTH, 128: number of ROM steps; must be ≥2.
- NUM, 25: synth channel count.
- C, 12: pitch width in bits.
- VOICES, 6: voice words per ROM entry.
- SPREAD, 4: channels per voice; even, ≥2; VOICES*SPREAD ≤ NUM.
- ROM_LATENCY, 1: cycles from rom_en to valid rom_data; must be ≥1.
- TEMPO_W, 16: width of tempo_div.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- play  in  1  level; 1 = run, 0 = pause
- stop  in  1  pulse; abort, return to step 0, silence outputs
- loop_mode  in  1  1 = wrap at song end; 0 = one-shot
- tempo_div  in  TEMPO_W  clk cycles per step
- rom_addr  out  $clog2(SONG_LENGTH)  ROM address
- rom_en  out  1  ROM read strobe
- rom_data  in  VOICES*16  packed voice words; voice v at [v*16 +: 16]
- demo_pitches  out  NUM*C  per-channel pitch
- demo_waveforms  out  NUM*2  per-channel waveform
- demo_channel_ena  out  NUM  per-channel enable
- playing  out  1  high in FETCH/WAIT/HOLD
- song_done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset (rst_n=0, async): state IDLE; rom_addr=0; rom_en=0; all demo_* outputs 0; playing=0; song_done=0.

Voice word fields:
- pitch = [15:4]; vol = [3:2]; wave = [1:0].
- Voice v owns channels [(VOICES-1-v)*SPREAD +: SPREAD].
- Every channel in the group receives that voice's pitch and wave.
- Enable by vol code: 0 → none; 1 → lowest channel of group; 2 → lowest SPREAD/2 channels; 3 → all SPREAD.
- Channels ≥ VOICES*SPREAD are tied to 0.

FSM transitions:
- IDLE: play=1 and stop=0 → FETCH.
- FETCH (1 cycle): rom_en=1 with current rom_addr; step counter loaded → WAIT.
- WAIT (ROM_LATENCY cycles): on its last cycle, all outputs are registered from rom_data together (no partial updates) → HOLD.
- HOLD: counter decrements only while play=1 (pause freezes the counter and holds the outputs). When the step count completes, branch at end of step:
  - rom_addr < SONG_LENGTH-1 → increment, FETCH.
  - Last step and loop_mode=1 → rom_addr=0, FETCH.
  - Last step and loop_mode=0 → DONE; song_done pulses for 1 cycle; outputs cleared.
- DONE: outputs 0; play=0 → IDLE (a new play edge restarts from step 0).

Step timing:
- Step length in cycles, counted from the FETCH cycle = max(tempo_div, ROM_LATENCY+2), excluding paused cycles.
- tempo_div is sampled in FETCH; a change mid-step takes effect next step.
- tempo_div=0 is treated as the minimum length.

Control corner cases:
- play deasserted during FETCH/WAIT: the fetch completes, then the block pauses in HOLD.
- stop (any state, synchronous): next state IDLE; rom_addr=0; outputs cleared; no song_done. stop wins over play in the same cycle.
- loop_mode is sampled only at end of the last step.
- rom_addr never reaches SONG_LENGTH.

Decomposition:
- Package demo_pkg holds:
  - voice-word field offsets (PITCH_LSB=4, VOL_LSB=2, WAVE_LSB=0);
  - VOICE_W=16;
  - state enum typedef {IDLE, FETCH, WAIT, HOLD, DONE};
  - packed struct typedef voice_t {pitch, vol, wave}.
- One sub-module: demo_voice_expand. It is purely combinational: maps one voice_t to SPREAD channels of pitch/wave/enable. It is instantiated VOICES times by generate; the top module registers its outputs.

Test Plan:
1. ROM_LATENCY=1, tempo_div=10, step 0 voice0 = 16'hABCF: outputs update 2 cycles after rom_en. Channels 20–23 show pitch 12'hABC, wave 2'b11, enables 4'b1111; channel 24 = 0. Next rom_en occurs exactly 10 cycles after the first.
2. Voice5 vol codes 0,1,2,3 on successive steps → channel_ena[3:0] = 0000, 0001, 0011, 1111.
3. SONG_LENGTH=4, loop_mode=0 → addresses 0,1,2,3, then song_done pulses once. Outputs go to 0 and rom_addr stays 0. playing=0 until play is toggled 0→1.
4. loop_mode=1 → addresses 0,1,2,3,0,1 with no song_done; rom_addr never equals 4.
5. play dropped for 7 cycles mid-HOLD → outputs unchanged, and the next rom_en is delayed by exactly 7 cycles. stop asserted in WAIT → IDLE next cycle, outputs 0, rom_addr 0.
6. tempo_div=0 with ROM_LATENCY=3 → step length 5 cycles. Async rst_n low mid-HOLD → outputs 0 immediately, without waiting for a clk edge.
